// File: rtl/ucie_ctl_sb_cfg_tx_if.sv
// ucie_ctl_sb_cfg_tx_if: RDI config port, sideband link and status signals of the config TX buffer
interface ucie_ctl_sb_cfg_tx_if #(parameter int NC = 32);
  logic [NC-1:0] i_rdi_lp_cfg;
  logic          i_rdi_lp_cfg_valid;
  logic          o_rdi_pl_cfg_crd;
  logic          i_sb_link_up;
  logic          i_sb_tx_ready;
  logic          o_sb_data_valid;
  logic [NC-1:0] o_data_sent_sb;
  logic          o_fifo_full;
  logic          o_fifo_empty;
  logic          o_overflow_err;
  logic [15:0]   o_tx_count;
  modport master (
    output i_rdi_lp_cfg, i_rdi_lp_cfg_valid, i_sb_link_up, i_sb_tx_ready,
    input  o_rdi_pl_cfg_crd, o_sb_data_valid, o_data_sent_sb, o_fifo_full, o_fifo_empty, o_overflow_err, o_tx_count
  );
  modport slave (
    input  i_rdi_lp_cfg, i_rdi_lp_cfg_valid, i_sb_link_up, i_sb_tx_ready,
    output o_rdi_pl_cfg_crd, o_sb_data_valid, o_data_sent_sb, o_fifo_full, o_fifo_empty, o_overflow_err, o_tx_count
  );
endinterface

// File: rtl/ucie_ctl_sb_cfg_tx.sv
// ucie_ctl_sb_cfg_tx: credit-managed RDI sideband config TX FIFO.
// Define UCIE_CTL_SB_CFG_TX_STATS_EN to build the saturating o_tx_count pop counter.
module ucie_ctl_sb_cfg_tx #(
  parameter int NC         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  ucie_ctl_sb_cfg_tx_if.slave sb
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, INIT_CRD = 2'd1, ACTIVE = 2'd2;
  logic [1:0]    state;
  logic [NC-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   occ, ccnt;
  logic          crd, ovf, live, full, pop, push, drop;
  assign full  = occ == DEPTH;
  assign live  = state == INIT_CRD || state == ACTIVE;
  assign pop   = sb.o_sb_data_valid && sb.i_sb_tx_ready;
  assign push  = live && sb.i_rdi_lp_cfg_valid && (!full || pop);
  assign drop  = live && sb.i_rdi_lp_cfg_valid && full && !pop;
  assign sb.o_sb_data_valid  = state == ACTIVE && occ != '0;
  assign sb.o_data_sent_sb   = sb.o_sb_data_valid ? mem[head] : '0;
  assign sb.o_rdi_pl_cfg_crd = crd;
  assign sb.o_fifo_full      = full;
  assign sb.o_fifo_empty     = occ == '0;
  assign sb.o_overflow_err   = ovf;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      occ   <= '0;
      ccnt  <= '0;
      crd   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (drop) ovf <= 1'b1;
      // IDLE and link-down both flush the queue and abandon pending credits
      if (state == IDLE || !sb.i_sb_link_up) begin
        state <= (state == IDLE && sb.i_sb_link_up) ? INIT_CRD : IDLE;
        head  <= '0;
        tail  <= '0;
        occ   <= '0;
        ccnt  <= '0;
        crd   <= 1'b0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        if (push && !pop) occ <= occ + 1'b1;
        else if (pop && !push) occ <= occ - 1'b1;
        if (state == INIT_CRD) begin
          crd <= ccnt != DEPTH;
          if (ccnt == DEPTH) state <= ACTIVE;
          else ccnt <= ccnt + 1'b1;
        end else crd <= pop;
      end
    end
  end
  always_ff @(posedge i_clk) if (push) mem[tail] <= sb.i_rdi_lp_cfg;
`ifdef UCIE_CTL_SB_CFG_TX_STATS_EN
  logic [15:0] tx_count;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) tx_count <= '0;
    else if (pop && tx_count != 16'hFFFF) tx_count <= tx_count + 1'b1;
  end
  assign sb.o_tx_count = tx_count;
`else
  assign sb.o_tx_count = '0;
`endif
endmodule

// File: tb/tb_ucie_ctl_sb_cfg_tx.sv
// tb_ucie_ctl_sb_cfg_tx: directed plus random stimulus against a queue-based reference model
module tb_ucie_ctl_sb_cfg_tx;
  logic clk = 1'b0, rst_n = 1'b0;
  int   n_chk = 0, n_fail = 0, pulses;
  logic [31:0] q[$];
  int   age = -1, mcnt = 0;
  bit   movf = 0, mcrd = 0;
  always #5 clk = ~clk;
  ucie_ctl_sb_cfg_tx_if #(.NC(32)) sb();
  ucie_ctl_sb_cfg_tx #(.NC(32), .FIFO_DEPTH(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .sb(sb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // age counts edges since link-up was seen in idle: 0..4 credit phase, >=5 active, -1 idle
  task automatic step();
    bit init, act, pop, push, vld;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); age = -1; movf = 0; mcnt = 0; mcrd = 0;
    end else begin
      init = age >= 0 && age <= 4;
      act  = age >= 5;
      pop  = act && q.size() > 0 && sb.i_sb_tx_ready;
      push = (init || act) && sb.i_rdi_lp_cfg_valid && (q.size() < 4 || pop);
      if ((init || act) && sb.i_rdi_lp_cfg_valid && q.size() == 4 && !pop) movf = 1;
      if (pop) begin
        void'(q.pop_front());
        if (mcnt < 65535) mcnt++;
      end
      if (push) q.push_back(sb.i_rdi_lp_cfg);
      if (age < 0) begin
        mcrd = 0; q.delete();
        if (sb.i_sb_link_up) age = 0;
      end else if (!sb.i_sb_link_up) begin
        age = -1; mcrd = 0; q.delete();
      end else begin
        mcrd = (age < 4) || pop;
        if (age < 5) age++;
      end
    end
    #1;
    vld = age >= 5 && q.size() > 0;
    check("crd", 32'(sb.o_rdi_pl_cfg_crd), 32'(mcrd));
    check("valid", 32'(sb.o_sb_data_valid), 32'(vld));
    check("data", sb.o_data_sent_sb, vld ? q[0] : 32'h0);
    check("full", 32'(sb.o_fifo_full), 32'(q.size() == 4));
    check("empty", 32'(sb.o_fifo_empty), 32'(q.size() == 0));
    check("ovf", 32'(sb.o_overflow_err), 32'(movf));
`ifdef UCIE_CTL_SB_CFG_TX_STATS_EN
    check("tx_count", 32'(sb.o_tx_count), 32'(mcnt));
`else
    check("tx_count", 32'(sb.o_tx_count), 32'h0);
`endif
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit rdy);
    sb.i_rdi_lp_cfg_valid = v;
    sb.i_rdi_lp_cfg = d;
    sb.i_sb_tx_ready = rdy;
    step();
  endtask

  initial begin
    sb.i_rdi_lp_cfg = '0; sb.i_rdi_lp_cfg_valid = 0; sb.i_sb_link_up = 0; sb.i_sb_tx_ready = 0;
    repeat (3) step();
    rst_n = 1;
    step();
    sb.i_sb_link_up = 1;
    pulses = 0;
    repeat (7) begin
      step();
      pulses += 32'(sb.o_rdi_pl_cfg_crd);
    end
    check("init_crd_pulses", pulses, 4);
    drive(1, 32'hA5A5_0001, 1);
    repeat (3) drive(0, 32'h0, 1);
    for (int i = 1; i <= 5; i++) drive(1, 32'(i), 0);
    drive(1, 32'h6, 1);
    pulses = 0;
    repeat (6) begin
      drive(0, 32'h0, 1);
      pulses += 32'(sb.o_rdi_pl_cfg_crd);
    end
    check("drain_crd_pulses", pulses, 4);
    for (int i = 7; i <= 9; i++) drive(1, 32'(i), 0);
    sb.i_sb_link_up = 0;
    drive(0, 32'h0, 0);
    drive(0, 32'h0, 0);
    sb.i_sb_link_up = 1;
    repeat (3) drive(0, 32'h0, 0);
    rst_n = 0;
    drive(0, 32'h0, 0);
    rst_n = 1;
    repeat (8) drive(0, 32'h0, 0);
    for (int i = 0; i < 1500; i++) begin
      sb.i_sb_link_up = ($urandom % 80) != 0;
      rst_n = ($urandom % 400) != 0;
      drive(1'($urandom % 3 != 0), $urandom, 1'($urandom % 3 == 0 ? 0 : 1));
    end
    rst_n = 1;
    sb.i_sb_link_up = 1;
    repeat (8) drive(0, 32'h0, 0);
    for (int i = 0; i < 6; i++) drive(1, $urandom, 0);
    repeat (6) drive(0, 32'h0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ucie_ctl_sb_cfg_tx.md
# ucie_ctl_sb_cfg_tx

Credit-managed transmit buffer for the RDI sideband configuration channel. It accepts config words from the adapter on `lp_cfg` and returns credits on `pl_cfg_crd`. It forwards the buffered words to the PHY sideband link on `o_data_sent_sb` / `o_sb_data_valid` under a ready handshake. The block sits between the adapter-facing RDI config port and the sideband serializer, on the transmit side of the PHY block.

## Interface
Parameters:
- `NC`, 32, config/sideband word width.
- `FIFO_DEPTH`, 4, buffer entries. Must be a power of 2, ≥ 2. This is also the initial credit count.

Ports:
- `i_clk`  in  1  single clock for the whole block.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_rdi_lp_cfg`  in  NC  config word from the adapter.
- `i_rdi_lp_cfg_valid`  in  1  `i_rdi_lp_cfg` valid this cycle (push request).
- `o_rdi_pl_cfg_crd`  out  1  one credit returned to the adapter per high cycle.
- `i_sb_link_up`  in  1  sideband link trained; low = link down.
- `i_sb_tx_ready`  in  1  sideband serializer can take a word this cycle.
- `o_sb_data_valid`  out  1  `o_data_sent_sb` valid.
- `o_data_sent_sb`  out  NC  FIFO head word.
- `o_fifo_full`  out  1  occupancy == FIFO_DEPTH.
- `o_fifo_empty`  out  1  occupancy == 0.
- `o_overflow_err`  out  1  sticky; a push was dropped because the FIFO was full.
- `o_tx_count`  out  16  words sent (see Configuration).

## Operation
- FSM states: IDLE, INIT_CRD, ACTIVE. Reset forces IDLE.
- **IDLE**
  - Pointers and occupancy are cleared every cycle. Pushes are ignored and set no error.
  - `i_sb_link_up` sampled high → INIT_CRD.
- **INIT_CRD**
  - `o_rdi_pl_cfg_crd` is high for exactly FIFO_DEPTH consecutive cycles, then → ACTIVE.
  - Pushes are accepted; the adapter may spend credits as they arrive.
  - No pops: `o_sb_data_valid` = 0.
- **ACTIVE**
  - Push:
    - A push happens when `i_rdi_lp_cfg_valid` = 1 and either (not full) or (pop in the same cycle).
    - Data is written at the tail and the tail advances, wrapping modulo FIFO_DEPTH.
  - Pop:
    - A pop happens when `o_sb_data_valid` && `i_sb_tx_ready`; the head advances and wraps.
  - Credit return: each pop produces one `o_rdi_pl_cfg_crd` high cycle.
- **Overflow**
  - Condition: `i_rdi_lp_cfg_valid` while full with no simultaneous pop, in INIT_CRD or ACTIVE.
  - The word is dropped, occupancy is unchanged, and `o_overflow_err` ← 1.
  - `o_overflow_err` clears only on reset.
- **Link down:** `i_sb_link_up` sampled low in INIT_CRD or ACTIVE → IDLE next cycle.
  - Contents are discarded and unfinished credit pulses are abandoned.
  - `o_overflow_err` is held.
- **Occupancy:** a (log2(FIFO_DEPTH)+1)-bit counter; +1 push only, −1 pop only, unchanged for both or neither.
- **Simultaneous push and pop:**
  - When empty: no pop is possible (valid = 0). The pushed word appears next cycle.
  - When full: both happen, occupancy stays FIFO_DEPTH, no error.

## Timing
- All outputs are registered or derived from registers; there is no combinational path from inputs to outputs.
- Reset values:
  - `o_rdi_pl_cfg_crd` = 0, `o_sb_data_valid` = 0, `o_data_sent_sb` = 0.
  - `o_fifo_full` = 0, `o_fifo_empty` = 1, `o_overflow_err` = 0, `o_tx_count` = 0.
- **Push-to-output latency:** 1 cycle. A word pushed at edge N into an empty FIFO in ACTIVE has `o_sb_data_valid` = 1 from edge N.
- **Head hold:** `o_data_sent_sb` is the head word. It is stable while `o_sb_data_valid` = 1 and `i_sb_tx_ready` = 0.
- **Credit latency:** a pop at edge N gives `o_rdi_pl_cfg_crd` high in the cycle after edge N, for 1 cycle.
  - Pops on k consecutive edges give k consecutive credit cycles.
- **Initial credits:** `i_sb_link_up` sampled high at edge N in IDLE gives `o_rdi_pl_cfg_crd` high from edge N+1 through edge N+FIFO_DEPTH.
  - The FSM is in ACTIVE from edge N+FIFO_DEPTH+1.
- **Reset mid-operation:** synchronous.
  - Takes effect at the first edge with `i_rst_n` = 0.
  - All state and outputs return to reset values; in-flight credits are lost.

## Configuration
- Macro: `UCIE_CTL_SB_CFG_TX_STATS_EN`.
- **Defined:**
  - `o_tx_count` increments by 1 on every pop.
  - It saturates at 16'hFFFF, is cleared by reset only, and holds across link-down.
- **Not defined:** `o_tx_count` is tied to 0 and no counter logic is built. The port list is identical in both builds.

## Test plan
All scenarios use NC = 32, FIFO_DEPTH = 4.
- **Bring-up:** reset, then `i_sb_link_up` = 1 → `o_rdi_pl_cfg_crd` high exactly 4 consecutive cycles, then ACTIVE; `o_fifo_empty` = 1 throughout.
- **Pass-through:** push 32'hA5A5_0001 with `i_sb_tx_ready` = 1 → `o_sb_data_valid` = 1 one cycle later with that word; one credit pulse the cycle after the pop; `o_tx_count` = 1 when the macro is defined.
- **Backpressure and overflow:**
  - Hold `i_sb_tx_ready` = 0 and push 32'h1, 32'h2, 32'h3, 32'h4, 32'h5.
  - Required: `o_fifo_full` = 1 after the 4th push; the 5th push is dropped and `o_overflow_err` = 1.
  - Then release ready: output order is 1, 2, 3, 4 with exactly 4 credit pulses.
- **Full push+pop:** with the FIFO full, push 32'h6 in the same cycle a pop of 32'h1 occurs → occupancy stays 4, `o_overflow_err` unchanged, 32'h6 is output after 32'h4.
- **Link drop:** with 3 entries queued, drop `i_sb_link_up` → IDLE next cycle, `o_fifo_empty` = 1, `o_sb_data_valid` = 0, no credits. Reassert `i_sb_link_up` → 4 fresh credit pulses.
- **Mid-operation reset:** assert `i_rst_n` = 0 during the INIT_CRD pulse train → all outputs at reset values at the next edge, including a cleared `o_overflow_err`.
